fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch front end; issues PC-ordered requests, queues returned words, flushes stale ones on redirect.
// Latency: a kept response is visible at instr_valid_D one cycle after it arrives (no bypass).
// Backpressure: requests stall while queued + in-flight reaches DEPTH; decode stalls the queue with instr_ready_D.
// Ports: clk/reset; PCSrc_F/PCBranch_F and EProc_F/EVAddr_F redirects (exception wins);
//        imem_req_*/imem_addr_F request side; imem_rsp_* in-order response side;
//        instr_*_D queue head toward decode; NextPC_F next PC value; flushing_F stale responses pending.
module fetch_unit #(
  parameter int             N        = 64,
  parameter int             DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  input  logic         EProc_F,
  input  logic [N-1:0] EVAddr_F,
  output logic         imem_req_valid_F,
  input  logic         imem_req_ready_F,
  output logic [N-1:0] imem_addr_F,
  input  logic         imem_rsp_valid_F,
  input  logic [31:0]  imem_rsp_data_F,
  output logic         instr_valid_D,
  input  logic         instr_ready_D,
  output logic [31:0]  instr_D,
  output logic [N-1:0] instr_pc_D,
  output logic [N-1:0] NextPC_F,
  output logic         flushing_F
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state_q, state_n;
  logic [N-1:0]  pc_q;
  logic [N-1:0]  rsp_pc_q;
  logic [31:0]   q_dat [DEPTH];
  logic [N-1:0]  q_pc  [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, inflight_q, drop_q, drop_n;
  logic [31:0]   hold_dat_q;
  logic [N-1:0]  hold_pc_q;

  logic          redirect;
  logic [N-1:0]  redirect_pc;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  logic [CW:0]   occupied;

  assign redirect    = EProc_F | PCSrc_F;
  assign redirect_pc = EProc_F ? EVAddr_F : PCBranch_F;

  // Queue slots already promised: entries waiting for decode plus requests still out in memory.
  assign occupied         = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_valid_F = !reset && !redirect && (occupied < (CW+1)'(DEPTH));
  assign imem_addr_F      = pc_q;
  assign req_fire         = imem_req_valid_F & imem_req_ready_F;

  always_comb begin
    NextPC_F = pc_q;
    if (EProc_F) begin
      NextPC_F = EVAddr_F;
    end else if (PCSrc_F) begin
      NextPC_F = PCBranch_F;
    end else if (req_fire) begin
      NextPC_F = pc_q + N'(4);
    end
  end

  // Only responses that belong to the current PC stream enter the queue.
  assign rsp_keep = imem_rsp_valid_F && !redirect && (state_q == RUN);

  assign instr_valid_D = (count_q != '0);
  assign pop           = instr_valid_D & instr_ready_D;

  // When empty, the head outputs keep showing whatever was last presented.
  assign instr_D    = instr_valid_D ? q_dat[rd_ptr_q] : hold_dat_q;
  assign instr_pc_D = instr_valid_D ? q_pc[rd_ptr_q]  : hold_pc_q;

  assign flushing_F = (state_q == FLUSH);

  // Drop counter / state: a redirect turns every outstanding request (other than a
  // response landing this very cycle) into one that must be discarded.
  always_comb begin
    drop_n  = drop_q;
    state_n = state_q;
    if (redirect) begin
      drop_n = inflight_q - CW'(imem_rsp_valid_F);
    end else if ((state_q == FLUSH) && imem_rsp_valid_F) begin
      drop_n = drop_q - CW'(1);
    end
    state_n = (drop_n != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      state_q    <= RUN;
      hold_dat_q <= '0;
      hold_pc_q  <= '0;
    end else begin
      pc_q       <= NextPC_F;
      inflight_q <= inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_F);
      drop_q     <= drop_n;
      state_q    <= state_n;
      hold_dat_q <= instr_D;
      hold_pc_q  <= instr_pc_D;
      if (redirect) begin
        rsp_pc_q <= redirect_pc;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (rsp_keep) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
          rsp_pc_q <= rsp_pc_q + N'(4);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      q_dat[wr_ptr_q] <= imem_rsp_data_F;
      q_pc[wr_ptr_q]  <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  // Request throttling guarantees a free slot for every kept response.
  assert property (@(posedge clk) disable iff (reset) rsp_keep |-> (count_q < CW'(DEPTH)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: randomized + directed check of fetch_unit against a queue-based reference model.
// Latency: memory model answers in request order, one cycle or later after the handshake.
// Backpressure: memory ready and decode ready are driven directly by the stimulus.
module tb_fetch_unit;
  localparam int             N       = 64;
  localparam int             DEPTH   = 4;
  localparam logic [N-1:0]   WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, PCSrc_F, EProc_F, imem_req_ready_F, imem_rsp_valid_F, instr_ready_D;
  logic [N-1:0] PCBranch_F, EVAddr_F;
  logic [31:0]  imem_rsp_data_F;
  logic         imem_req_valid_F, instr_valid_D, flushing_F;
  logic [N-1:0] imem_addr_F, instr_pc_D, NextPC_F;
  logic [31:0]  instr_D;

  logic         w_req_valid, w_instr_valid, w_flushing;
  logic [N-1:0] w_addr, w_instr_pc, w_next_pc;
  logic [31:0]  w_instr;

  fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F), .EProc_F(EProc_F), .EVAddr_F(EVAddr_F),
    .imem_req_valid_F(imem_req_valid_F), .imem_req_ready_F(imem_req_ready_F), .imem_addr_F(imem_addr_F),
    .imem_rsp_valid_F(imem_rsp_valid_F), .imem_rsp_data_F(imem_rsp_data_F),
    .instr_valid_D(instr_valid_D), .instr_ready_D(instr_ready_D), .instr_D(instr_D), .instr_pc_D(instr_pc_D),
    .NextPC_F(NextPC_F), .flushing_F(flushing_F)
  );

  fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset),
    .PCSrc_F(1'b0), .PCBranch_F('0), .EProc_F(1'b0), .EVAddr_F('0),
    .imem_req_valid_F(w_req_valid), .imem_req_ready_F(1'b1), .imem_addr_F(w_addr),
    .imem_rsp_valid_F(1'b0), .imem_rsp_data_F(32'h0),
    .instr_valid_D(w_instr_valid), .instr_ready_D(1'b1), .instr_D(w_instr), .instr_pc_D(w_instr_pc),
    .NextPC_F(w_next_pc), .flushing_F(w_flushing)
  );

  typedef struct {
    logic [N-1:0] addr;
    bit           stale;
  } mreq_t;

  mreq_t        mem_q[$];   // requests accepted by memory, not yet answered
  logic [N-1:0] sb[$];      // PCs decode must still receive, in order
  logic [N-1:0] model_pc;
  bit           exp_vld;
  bit           rsp_hold, rsp_rand;
  int           total, bad, cyc, hs_cnt, first_req_cyc, first_vld_cyc;

  function automatic logic [31:0] memfn(input logic [N-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Pre-edge view: what the DUT must show given the requests/responses seen so far.
  task automatic check_phase();
    logic [N-1:0] en;
    cyc++;
    if (reset) begin
      chk("req_valid_in_reset", imem_req_valid_F, 1'b0);
      exp_vld = 0;
      return;
    end
    exp_vld = !(EProc_F || PCSrc_F) && ((sb.size() + stale_cnt()) < DEPTH);
    chk("req_valid", imem_req_valid_F, exp_vld);
    chk("fetch_addr", imem_addr_F, model_pc);
    chk("flushing", flushing_F, stale_cnt() > 0);
    en = EProc_F ? EVAddr_F : PCSrc_F ? PCBranch_F : (exp_vld && imem_req_ready_F) ? model_pc + 64'd4 : model_pc;
    chk("next_pc", NextPC_F, en);
    if (exp_vld && first_req_cyc < 0) first_req_cyc = cyc;
    if (instr_valid_D && first_vld_cyc < 0) first_vld_cyc = cyc;
  endtask

  task automatic update_model();
    mreq_t m;
    if (reset) begin
      mem_q.delete();
      sb.delete();
      model_pc = '0;
      return;
    end
    if (imem_rsp_valid_F && mem_q.size() > 0) void'(mem_q.pop_front());
    if (EProc_F || PCSrc_F) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      sb.delete();
      model_pc = EProc_F ? EVAddr_F : PCBranch_F;
    end else if (exp_vld && imem_req_ready_F) begin
      m.addr  = model_pc;
      m.stale = 1'b0;
      mem_q.push_back(m);
      sb.push_back(model_pc);
      model_pc = model_pc + 64'd4;
      hs_cnt++;
    end
  endtask

  task automatic drive_mem();
    if (mem_q.size() > 0 && !rsp_hold && (!rsp_rand || $urandom_range(3) != 0)) begin
      imem_rsp_valid_F = 1'b1;
      imem_rsp_data_F  = memfn(mem_q[0].addr);
    end else begin
      imem_rsp_valid_F = 1'b0;
      imem_rsp_data_F  = $urandom;
    end
  endtask

  // One clock: check before the edge, update model, then drive the next cycle's memory side.
  task automatic step();
    @(negedge clk);
    check_phase();
    #2;
    update_model();
    @(posedge clk);
    #1;
    drive_mem();
    PCSrc_F = 1'b0;
    EProc_F = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    hs_cnt = 0;
  endtask

  // Monitor: every decode handshake must match the oldest expected PC.
  initial begin
    logic [N-1:0] exp_pc;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && instr_valid_D && instr_ready_D) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deliver_unexpected: got pc %0h, expected no delivery", instr_pc_D);
        end else begin
          exp_pc = sb.pop_front();
          chk("instr_pc", instr_pc_D, exp_pc);
          chk("instr_data", instr_D, memfn(exp_pc));
        end
      end
    end
  end

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; hs_cnt = 0;
    first_req_cyc = -1; first_vld_cyc = -1;
    reset = 1'b1; PCSrc_F = 1'b0; EProc_F = 1'b0; PCBranch_F = '0; EVAddr_F = '0;
    imem_req_ready_F = 1'b1; imem_rsp_valid_F = 1'b0; imem_rsp_data_F = '0; instr_ready_D = 1'b1;
    rsp_hold = 0; rsp_rand = 0; model_pc = '0;

    repeat (2) step();
    chk("rst_req_valid", imem_req_valid_F, 1'b0);
    chk("rst_instr_valid", instr_valid_D, 1'b0);
    chk("rst_instr", instr_D, 32'h0);
    chk("rst_instr_pc", instr_pc_D, '0);
    chk("rst_flushing", flushing_F, 1'b0);
    chk("rst_addr", imem_addr_F, '0);

    // Sequential streaming with a 1-cycle memory; wrap instance walks over the top of the address space.
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_addr", w_addr, WRAP_PC + 64'(4 * i));
      chk("wrap_valid", w_req_valid, 1'b1);
      chk("wrap_next_pc", w_next_pc, WRAP_PC + 64'(4 * i + 4));
      chk("wrap_idle_outputs", {w_instr_valid, w_flushing, w_instr, w_instr_pc[31:0]}, '0);
      step();
    end
    repeat (6) step();
    chk("first_rsp_latency", 64'(first_vld_cyc - first_req_cyc), 64'd2);

    // Decode stalled: exactly DEPTH requests, then the queue holds 0..12.
    do_reset();
    instr_ready_D = 1'b0;
    repeat (10) step();
    chk("full_req_count", 64'(hs_cnt), 64'(DEPTH));
    chk("full_req_valid", imem_req_valid_F, 1'b0);
    chk("full_head_pc", instr_pc_D, '0);
    instr_ready_D = 1'b1;
    repeat (8) step();

    // Branch redirect with two requests outstanding.
    do_reset();
    rsp_hold = 1;
    step();
    step();
    imem_req_ready_F = 1'b0;
    PCSrc_F = 1'b1;
    PCBranch_F = 64'h100;
    rsp_hold = 0;
    step();
    chk("flush_entered", flushing_F, 1'b1);
    imem_req_ready_F = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!flushing_F) break;
      if (imem_rsp_valid_F) n++;
      step();
    end
    chk("flush_ended", flushing_F, 1'b0);
    chk("flush_drops", 64'(n), 64'd2);
    for (int k = 0; k < 20; k++) begin
      if (instr_valid_D) break;
      step();
    end
    chk("after_branch_valid", instr_valid_D, 1'b1);
    chk("after_branch_pc", instr_pc_D, 64'h100);

    // Exception and branch together: exception vector wins.
    step();
    EProc_F = 1'b1; EVAddr_F = 64'h400;
    PCSrc_F = 1'b1; PCBranch_F = 64'h100;
    #1;
    chk("prio_next_pc", NextPC_F, 64'h400);
    step();
    chk("prio_fetch_addr", imem_addr_F, 64'h400);
    repeat (6) step();

    // Reset with two queued entries and two requests in flight.
    do_reset();
    instr_ready_D = 1'b0;
    rsp_hold = 1;
    repeat (4) step();
    rsp_hold = 0;
    step();
    step();
    rsp_hold = 1;
    step();
    chk("prerst_queue_valid", instr_valid_D, 1'b1);
    chk("prerst_req_valid", imem_req_valid_F, 1'b0);
    reset = 1'b1;
    step();
    chk("midrst_req_valid", imem_req_valid_F, 1'b0);
    chk("midrst_instr_valid", instr_valid_D, 1'b0);
    chk("midrst_instr", instr_D, 32'h0);
    chk("midrst_instr_pc", instr_pc_D, '0);
    chk("midrst_flushing", flushing_F, 1'b0);
    chk("midrst_addr", imem_addr_F, '0);
    reset = 1'b0;
    rsp_hold = 0;
    instr_ready_D = 1'b1;

    // Randomized traffic with redirects, stalls and occasional resets.
    rsp_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(63);
      imem_req_ready_F = ($urandom_range(3) != 0);
      instr_ready_D    = ($urandom_range(2) != 0);
      reset            = ($urandom_range(299) == 0);
      if (r == 0) begin
        EProc_F  = 1'b1;
        EVAddr_F = {$urandom, $urandom} & ~64'h3;
      end
      if (r <= 3) begin
        PCSrc_F    = 1'b1;
        PCBranch_F = (r == 3) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3) * 4))
                              : ({$urandom, $urandom} & ~64'h3);
      end
      step();
    end

    // Drain: no new requests, everything expected must reach decode.
    reset = 1'b0;
    rsp_rand = 0;
    imem_req_ready_F = 1'b0;
    instr_ready_D = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0 && mem_q.size() == 0) break;
      step();
    end
    step();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_instr_valid", instr_valid_D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
